// File: rtl/mir_seq_pkg.sv
// rtl/mir_seq_pkg.sv - shared constants and types for the mir_seq sequencer
//
// Purpose: opcode constants, microword field bounds, microword constants and
// the FSM state encoding shared by mir_seq, mir_seq_rom and their bench.
// Ports: none (package).

package mir_seq_pkg;

  // Native microword width; the sequencer resizes to its UINST_W parameter.
  localparam int UW = 34;

  // Microword field bounds (MSB..LSB):
  //   M[33:32] KMX[31] T[30:28] BUSC[27:22] BUSB[21:16] BUSA[15:10]
  //   SH[9:7] ALUC[6:0]
  localparam int iM_H    = 33;
  localparam int iM_L    = 32;
  localparam int iKMX    = 31;
  localparam int iT_H    = 30;
  localparam int iT_L    = 28;
  localparam int iBUSC_H = 27;
  localparam int iBUSC_L = 22;
  localparam int iBUSB_H = 21;
  localparam int iBUSB_L = 16;
  localparam int iBUSA_H = 15;
  localparam int iBUSA_L = 10;
  localparam int iSH_H   = 9;
  localparam int iSH_L   = 7;
  localparam int iALUC_H = 6;
  localparam int iALUC_L = 0;

  // Opcode nybble values. 4'h0 also decodes as NOP; 4'hA..4'hF are illegal.
  localparam logic [3:0] NOP_i  = 4'h1;
  localparam logic [3:0] CLC_i  = 4'h2;
  localparam logic [3:0] SEC_i  = 4'h3;
  localparam logic [3:0] CPLw_i = 4'h4;
  localparam logic [3:0] SHLw_i = 4'h5;
  localparam logic [3:0] SHRw_i = 4'h6;
  localparam logic [3:0] ASRw_i = 4'h7;
  localparam logic [3:0] INCw_i = 4'h8;
  localparam logic [3:0] DECw_i = 4'h9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Builds a microword from its fields; KMX and M are never set.
  function automatic logic [UW-1:0] mk_uword(
    input logic [6:0] aluc,
    input logic [2:0] sh,
    input logic [5:0] busa,
    input logic [5:0] busb,
    input logic [5:0] busc,
    input logic [2:0] t
  );
    logic [UW-1:0] w;
    w                   = '0;
    w[iALUC_H:iALUC_L]  = aluc;
    w[iSH_H:iSH_L]      = sh;
    w[iBUSA_H:iBUSA_L]  = busa;
    w[iBUSB_H:iBUSB_L]  = busb;
    w[iBUSC_H:iBUSC_L]  = busc;
    w[iT_H:iT_L]        = t;
    return w;
  endfunction

  // Bus codes: 1 = W register, 2 = constant one. T codes: 1 = flags, 2 = W.
  localparam logic [UW-1:0] NOP_u  = '0;
  localparam logic [UW-1:0] CLC_u  = mk_uword(7'h01, 3'd0, 6'd0, 6'd0, 6'd0, 3'd1);
  localparam logic [UW-1:0] SEC_u  = mk_uword(7'h02, 3'd0, 6'd0, 6'd0, 6'd0, 3'd1);
  localparam logic [UW-1:0] CPLw_u = mk_uword(7'h10, 3'd0, 6'd1, 6'd0, 6'd1, 3'd2);
  localparam logic [UW-1:0] SHLw_u = mk_uword(7'h20, 3'd1, 6'd1, 6'd0, 6'd1, 3'd2);
  localparam logic [UW-1:0] SHRw_u = mk_uword(7'h20, 3'd2, 6'd1, 6'd0, 6'd1, 3'd2);
  localparam logic [UW-1:0] ASRw_u = mk_uword(7'h20, 3'd3, 6'd1, 6'd0, 6'd1, 3'd2);
  localparam logic [UW-1:0] INCw_u = mk_uword(7'h04, 3'd0, 6'd1, 6'd2, 6'd1, 3'd2);
  localparam logic [UW-1:0] DECw_u = mk_uword(7'h08, 3'd0, 6'd1, 6'd2, 6'd1, 3'd2);

endpackage

// File: rtl/mir_seq_rom.sv
// rtl/mir_seq_rom.sv - combinational opcode to microword decode
//
// Purpose: maps a 4-bit opcode to its microword, flags unrecognised opcodes
// and marks the shift opcodes that may repeat.
// Ports:
//   opcode   in  4   opcode nybble
//   uword    out UW  decoded microword (NOP for illegal opcodes)
//   illegal  out 1   opcode is not recognised
//   is_shift out 1   opcode is SHLw, SHRw or ASRw

module mir_seq_rom
  import mir_seq_pkg::*;
(
  input  logic [3:0]    opcode,
  output logic [UW-1:0] uword,
  output logic          illegal,
  output logic          is_shift
);

  always_comb begin
    uword    = NOP_u;
    illegal  = 1'b0;
    is_shift = 1'b0;
    case (opcode)
      4'h0, NOP_i: uword = NOP_u;
      CLC_i:       uword = CLC_u;
      SEC_i:       uword = SEC_u;
      CPLw_i:      uword = CPLw_u;
      SHLw_i: begin
        uword    = SHLw_u;
        is_shift = 1'b1;
      end
      SHRw_i: begin
        uword    = SHRw_u;
        is_shift = 1'b1;
      end
      ASRw_i: begin
        uword    = ASRw_u;
        is_shift = 1'b1;
      end
      INCw_i:      uword = INCw_u;
      DECw_i:      uword = DECw_u;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mir_seq.sv
// rtl/mir_seq.sv - registered microinstruction sequencer with shift repeat
//
// Purpose: accepts decoded instructions over valid/ready and emits one or more
// identical microwords per instruction toward execute over valid/ready.
// Ports:
//   CLK, RESET        clock and synchronous active-high reset
//   INST, INST_VALID  instruction word in and its valid
//   INST_READY        sequencer takes INST this cycle
//   FLUSH             abort current sequence, drop pending output
//   MICROINST, UVALID registered microword out and its valid
//   UREADY            execute consumes MICROINST this cycle
//   ULAST             word is the final step of its instruction
//   STEP              zero-based step index within the sequence
//   ILLEGAL           word comes from an unrecognised opcode

module mir_seq
  import mir_seq_pkg::*;
#(
  parameter int INST_W     = 20,
  parameter int UINST_W    = 34,
  parameter int OPC_LSB    = 4,
  parameter int REPEAT_EN  = 1,
  parameter int MAX_REPEAT = 8,
  parameter int CNT_W      = $clog2(MAX_REPEAT + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INST_W-1:0]  INST,
  input  logic               INST_VALID,
  output logic               INST_READY,
  input  logic               FLUSH,
  output logic [UINST_W-1:0] MICROINST,
  output logic               UVALID,
  input  logic               UREADY,
  output logic               ULAST,
  output logic [CNT_W-1:0]   STEP,
  output logic               ILLEGAL
);

  state_t              state_q;
  logic [UINST_W-1:0]  uword_q;
  logic                ulast_q;
  logic                illegal_q;
  logic [CNT_W-1:0]    step_q;
  logic [CNT_W-1:0]    last_step_q;

  logic [UW-1:0]       rom_uword;
  logic                rom_illegal;
  logic                rom_is_shift;
  logic [3:0]          req_cnt;
  logic [CNT_W-1:0]    acc_last_step;
  logic                consume;
  logic                accept;

  // Only the opcode nybble and the repeat field are decoded.
  logic unused_inst;
  assign unused_inst = ^INST;

  mir_seq_rom u_rom (
    .opcode   (INST[OPC_LSB +: 4]),
    .uword    (rom_uword),
    .illegal  (rom_illegal),
    .is_shift (rom_is_shift)
  );

  // Repeat count is fixed at accept time: 0 means one step, then clip.
  always_comb begin
    req_cnt = 4'd1;
    if (REPEAT_EN != 0 && rom_is_shift) begin
      req_cnt = (INST[3:0] == 4'd0) ? 4'd1 : INST[3:0];
      if (req_cnt > 4'(MAX_REPEAT)) begin
        req_cnt = 4'(MAX_REPEAT);
      end
    end
    acc_last_step = CNT_W'(req_cnt - 4'd1);
  end

  assign UVALID     = (state_q == ST_RUN);
  assign consume    = UVALID & UREADY;
  // A new instruction may only overlap the consume of the final step, so the
  // output register is never overwritten while a word is still pending.
  assign INST_READY = !RESET & !FLUSH & ((state_q == ST_IDLE) | (consume & ulast_q));
  assign accept     = INST_VALID & INST_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      uword_q     <= UINST_W'(NOP_u);
      ulast_q     <= 1'b0;
      illegal_q   <= 1'b0;
      step_q      <= '0;
      last_step_q <= '0;
    end else if (FLUSH) begin
      // Flushing an idle sequencer leaves its outputs untouched.
      if (state_q == ST_RUN) begin
        state_q     <= ST_IDLE;
        uword_q     <= UINST_W'(NOP_u);
        ulast_q     <= 1'b0;
        illegal_q   <= 1'b0;
        step_q      <= '0;
        last_step_q <= '0;
      end
    end else if (accept) begin
      state_q     <= ST_RUN;
      uword_q     <= UINST_W'(rom_uword);
      illegal_q   <= rom_illegal;
      step_q      <= '0;
      last_step_q <= acc_last_step;
      ulast_q     <= (acc_last_step == '0);
    end else if (consume) begin
      if (ulast_q) begin
        state_q   <= ST_IDLE;
        ulast_q   <= 1'b0;
        illegal_q <= 1'b0;
        step_q    <= '0;
      end else begin
        step_q  <= step_q + CNT_W'(1);
        ulast_q <= ((step_q + CNT_W'(1)) == last_step_q);
      end
    end
  end

  assign MICROINST = uword_q;
  assign ULAST     = ulast_q;
  assign STEP      = step_q;
  assign ILLEGAL   = illegal_q;

endmodule
